// File: rtl/io_switch_debounce.sv
// Purpose: two-flop sync plus per-bit stability-counter debounce of raw switch/key levels.
// Latency: a held level change is accepted at edge CNT_MAX+2; rise_pulse/event_flags update on that edge.
// Backpressure: none; free-running, evt_clr clears the sticky flags but a coincident press wins.
module io_switch_debounce #(
  parameter int WIDTH   = 10,
  parameter int CNT_MAX = 50000,
  parameter int CNT_W   = 16
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             evt_clr,
  output logic [31:0]      port_data,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] event_flags
);

  typedef enum logic {ST_LOW = 1'b0, ST_HIGH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_flags;

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff      = r_s2[g] ^ (r_state == ST_HIGH);
    assign w_stable[g] = (r_state == ST_HIGH);
    assign w_rise[g]   = w_diff && (r_cnt == LP_LAST) && (r_state == ST_LOW);

    // Any agreeing cycle restarts the count, so only an unbroken run flips the state.
    always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
        r_state <= ST_LOW;
        r_cnt   <= '0;
      end else if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_state <= (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Clear and set in the same cycle keeps the flag so no press is lost.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_rise  <= '0;
      r_flags <= '0;
    end else begin
      r_rise  <= w_rise;
      r_flags <= (evt_clr ? '0 : r_flags) | w_rise;
    end
  end

  always_comb begin
    port_data              = '0;
    port_data[WIDTH-1:0]   = w_stable;
  end

  assign rise_pulse  = r_rise;
  assign event_flags = r_flags;

endmodule

// File: tb/tb_io_switch_debounce.sv
// Directed bench for io_switch_debounce with CNT_MAX=4: expectations queued per step, checked after each edge.
module tb_io_switch_debounce;

  localparam int WIDTH   = 10;
  localparam int CNT_MAX = 4;
  localparam int CNT_W   = 4;

  logic             io_clk;
  logic             resetn;
  logic [WIDTH-1:0] raw_in;
  logic             evt_clr;
  logic [31:0]      port_data;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] event_flags;

  typedef struct {
    string            tag;
    logic [31:0]      pd;
    logic [WIDTH-1:0] rp;
    logic [WIDTH-1:0] ef;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  io_switch_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .io_clk      (io_clk),
    .resetn      (resetn),
    .raw_in      (raw_in),
    .evt_clr     (evt_clr),
    .port_data   (port_data),
    .rise_pulse  (rise_pulse),
    .event_flags (event_flags)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic push(input string tag, input logic [31:0] pd,
                      input logic [WIDTH-1:0] rp, input logic [WIDTH-1:0] ef);
    exp_t e;
    e.tag = tag; e.pd = pd; e.rp = rp; e.ef = ef;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed size 0 expected >0");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_assert++;
      assert (port_data === e.pd) else begin
        n_fail++;
        $error("FAIL %s port_data: observed %h expected %h", e.tag, port_data, e.pd);
      end
      n_assert++;
      assert (rise_pulse === e.rp) else begin
        n_fail++;
        $error("FAIL %s rise_pulse: observed %h expected %h", e.tag, rise_pulse, e.rp);
      end
      n_assert++;
      assert (event_flags === e.ef) else begin
        n_fail++;
        $error("FAIL %s event_flags: observed %h expected %h", e.tag, event_flags, e.ef);
      end
    end
  endtask

  // Advance one edge, sample 1ns later, compare against the queued expectation.
  task automatic tick(input string tag, input logic [31:0] pd,
                      input logic [WIDTH-1:0] rp, input logic [WIDTH-1:0] ef);
    push(tag, pd, rp, ef);
    @(posedge io_clk);
    #1;
    check_pop();
  endtask

  initial begin
    resetn  = 1'b0;
    raw_in  = '0;
    evt_clr = 1'b0;
    #2;
    push("reset_async", 32'h0, '0, '0);
    check_pop();
    repeat (2) @(posedge io_clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) tick("idle_zero", 32'h0, '0, '0);

    // Bit 0 rises: accepted at edge 6.
    raw_in = 10'h001;
    for (int i = 1; i <= 5; i++) tick("b0_counting", 32'h0, '0, '0);
    tick("b0_accept", 32'h1, 10'h001, 10'h001);
    tick("b0_pulse_end", 32'h1, 10'h000, 10'h001);
    tick("b0_hold", 32'h1, 10'h000, 10'h001);

    // Three-cycle glitch on bit 1 is rejected.
    raw_in = 10'h003;
    for (int i = 1; i <= 3; i++) tick("glitch_hi", 32'h1, '0, 10'h001);
    raw_in = 10'h001;
    for (int i = 0; i < 10; i++) tick("glitch_rej", 32'h1, '0, 10'h001);

    // All bits high: bit 0 already high so no pulse there.
    raw_in = 10'h3FF;
    for (int i = 1; i <= 5; i++) tick("all_counting", 32'h1, '0, 10'h001);
    tick("all_accept", 32'h3FF, 10'h3FE, 10'h3FF);
    tick("all_pulse_end", 32'h3FF, 10'h000, 10'h3FF);

    // All low: falling edges never pulse, flags stay.
    raw_in = 10'h000;
    for (int i = 1; i <= 5; i++) tick("fall_counting", 32'h3FF, '0, 10'h3FF);
    tick("fall_accept", 32'h0, 10'h000, 10'h3FF);
    tick("fall_hold", 32'h0, 10'h000, 10'h3FF);

    // evt_clr coincident with bit 2 rise: bit 2 flag survives.
    raw_in = 10'h004;
    for (int i = 1; i <= 5; i++) tick("b2_counting", 32'h0, '0, 10'h3FF);
    evt_clr = 1'b1;
    tick("clr_and_set", 32'h4, 10'h004, 10'h004);
    evt_clr = 1'b0;
    tick("clr_set_after", 32'h4, 10'h000, 10'h004);

    // evt_clr alone clears everything next cycle.
    evt_clr = 1'b1;
    tick("clr_alone", 32'h4, 10'h000, 10'h000);
    evt_clr = 1'b0;
    tick("clr_alone_hold", 32'h4, 10'h000, 10'h000);

    // Reset mid-count (cnt=2 after edge 4) then restart with raw held at 10'h004.
    raw_in = 10'h008;
    for (int i = 1; i <= 4; i++) tick("pre_rst_count", 32'h4, '0, '0);
    resetn = 1'b0;
    #1;
    push("rst_mid_count", 32'h0, '0, '0);
    check_pop();
    raw_in = 10'h004;
    @(posedge io_clk);
    #1;
    push("rst_held", 32'h0, '0, '0);
    check_pop();
    resetn = 1'b1;
    for (int i = 1; i <= 5; i++) tick("post_rst_count", 32'h0, '0, '0);
    tick("post_rst_accept", 32'h4, 10'h004, 10'h004);
    tick("post_rst_pulse_end", 32'h4, 10'h000, 10'h004);

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
